// File: rtl/noc_packet_sink_checker_pkg.sv
// -----------------------------------------------------------------------------
// noc_packet_sink_checker_pkg
// Shared NoC field geometry, error-bit indices, sink FSM state type and a
// saturating counter helper for the packet sink checker.
// Flit layout (header and tail):
//   [31:28] source X, [27:24] source Y, [23:20] dest X, [19:16] dest Y,
//   [15:0]  unused in header/tail.
// -----------------------------------------------------------------------------
package noc_packet_sink_checker_pkg;

  localparam int NOC_DATA_WIDTH   = 32;
  localparam int NOC_ID_X_WIDTH   = 4;
  localparam int NOC_ID_Y_WIDTH   = 4;
  localparam int NOC_ID_WIDTH     = NOC_ID_X_WIDTH + NOC_ID_Y_WIDTH;

  // Source ID occupies [NOC_POINT_H-1:NOC_SOURCE_POINT], dest ID sits directly below it.
  localparam int NOC_POINT_H      = 32;
  localparam int NOC_SOURCE_POINT = 24;
  localparam int NOC_DEST_POINT   = 16;

  localparam int NOC_PKT_ERR_WIDTH = 4;
  localparam int ERR_BAD_DEST      = 3;
  localparam int ERR_LEN           = 2;
  localparam int ERR_TAIL          = 1;
  localparam int ERR_DATA          = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } sink_state_e;

  // Add 0..2 to a 16-bit counter, clamping at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/noc_packet_sink_checker_lfsr8.sv
// -----------------------------------------------------------------------------
// noc_lfsr8
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, used to generate
// pseudo-random backpressure.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset, loads SEED
//   step_i   advance one state when high
//   state_o  current LFSR state
// -----------------------------------------------------------------------------
module noc_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       fb_s;

  // Next-state: shift left, feed back taps 8,6,5,4.
  always_comb begin
    fb_s = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    if (step_i) begin
      lfsr_d = {lfsr_q[6:0], fb_s};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/noc_packet_sink_checker.sv
// -----------------------------------------------------------------------------
// noc_packet_sink_checker
// Terminal receive endpoint for a router local port. Tracks header/data/tail
// packets, checks destination, length, data pattern and tail consistency, and
// reports one result per closed packet plus running good/error counters.
// Ports:
//   noc_clk, noc_rst            clock, synchronous active-high reset
//   receive_valid/ready         flit handshake (ready is registered)
//   receive_flit                flit payload
//   receive_is_header/is_tail   flit type markers
//   stall_en                    enable pseudo-random backpressure
//   pkt_done                    one-cycle pulse when a packet closes
//   pkt_src_x/y, pkt_len, pkt_err  result of last closed packet (held)
//   proto_err                   one-cycle pulse on a protocol violation
//   pkt_count, err_count        saturating good / error counters
// -----------------------------------------------------------------------------
module noc_packet_sink_checker
  import noc_packet_sink_checker_pkg::*;
#(
  parameter logic [NOC_ID_X_WIDTH-1:0] X_ID         = 4'd0,
  parameter logic [NOC_ID_Y_WIDTH-1:0] Y_ID         = 4'd0,
  parameter int                        EXP_DATA_LEN = 11,
  parameter logic [NOC_DATA_WIDTH-1:0] DATA_PATTERN = {NOC_DATA_WIDTH{1'b1}},
  parameter logic [7:0]                LFSR_SEED    = 8'hA5
) (
  input  logic                          noc_clk,
  input  logic                          noc_rst,
  input  logic                          receive_valid,
  output logic                          receive_ready,
  input  logic [NOC_DATA_WIDTH-1:0]     receive_flit,
  input  logic                          receive_is_header,
  input  logic                          receive_is_tail,
  input  logic                          stall_en,
  output logic                          pkt_done,
  output logic [NOC_ID_X_WIDTH-1:0]     pkt_src_x,
  output logic [NOC_ID_Y_WIDTH-1:0]     pkt_src_y,
  output logic [7:0]                    pkt_len,
  output logic [NOC_PKT_ERR_WIDTH-1:0]  pkt_err,
  output logic                          proto_err,
  output logic [15:0]                   pkt_count,
  output logic [15:0]                   err_count
);

  localparam logic [7:0]              EXP_LEN = 8'(EXP_DATA_LEN);
  localparam logic [NOC_ID_WIDTH-1:0] MY_ID   = {X_ID, Y_ID};

  // Backpressure source
  logic [7:0] lfsr_s;
  logic       unused_lfsr_s;

  noc_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (noc_clk),
    .rst_i   (noc_rst),
    .step_i  (1'b1),
    .state_o (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s[7:3];

  // Registered state
  sink_state_e                     state_q;
  logic [NOC_ID_WIDTH-1:0]         src_q;
  logic [NOC_ID_WIDTH-1:0]         dest_q;
  logic [7:0]                      len_q;
  logic                            bad_dest_q;
  logic                            data_err_q;
  logic                            ready_q;
  logic                            pkt_done_q;
  logic [NOC_ID_WIDTH-1:0]         pkt_src_q;
  logic [7:0]                      pkt_len_q;
  logic [NOC_PKT_ERR_WIDTH-1:0]    pkt_err_q;
  logic                            proto_err_q;
  logic [15:0]                     pkt_count_q;
  logic [15:0]                     err_count_q;

  // Decode
  logic                            accept_s;
  logic                            acc_hdr_s;
  logic                            acc_tail_s;
  logic                            acc_data_s;
  logic [NOC_ID_WIDTH-1:0]         flit_src_s;
  logic [NOC_ID_WIDTH-1:0]         flit_dest_s;
  logic                            flit_bad_dest_s;
  logic [7:0]                      len_inc_s;
  logic                            close_s;
  logic [NOC_PKT_ERR_WIDTH-1:0]    close_err_s;
  logic [7:0]                      close_len_s;
  logic [NOC_ID_WIDTH-1:0]         close_src_s;
  logic                            proto_s;
  logic [1:0]                      err_inc_s;
  logic                            ready_d;

  // Flit classification and per-packet close decision for this cycle.
  always_comb begin
    accept_s        = receive_valid & ready_q;
    acc_hdr_s       = accept_s & receive_is_header;
    acc_tail_s      = accept_s & ~receive_is_header & receive_is_tail;
    acc_data_s      = accept_s & ~receive_is_header & ~receive_is_tail;
    flit_src_s      = receive_flit[NOC_POINT_H-1:NOC_SOURCE_POINT];
    flit_dest_s     = receive_flit[NOC_SOURCE_POINT-1:NOC_DEST_POINT];
    flit_bad_dest_s = (flit_dest_s != MY_ID);
    len_inc_s       = (len_q == 8'hFF) ? 8'hFF : (len_q + 8'd1);

    close_s     = 1'b0;
    close_err_s = {NOC_PKT_ERR_WIDTH{1'b0}};
    close_len_s = len_q;
    close_src_s = src_q;
    proto_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acc_hdr_s && receive_is_tail) begin
          // Single-flit packet: header doubles as tail.
          close_s                   = 1'b1;
          close_len_s               = 8'd0;
          close_src_s               = flit_src_s;
          close_err_s[ERR_BAD_DEST] = flit_bad_dest_s;
          close_err_s[ERR_LEN]      = (EXP_LEN != 8'd0);
        end else if (accept_s && !receive_is_header) begin
          proto_s = 1'b1;
        end else begin
          proto_s = 1'b0;
        end
      end
      ST_BODY: begin
        if (acc_hdr_s) begin
          // Header inside a packet truncates the current one.
          proto_s                   = 1'b1;
          close_s                   = 1'b1;
          close_err_s[ERR_BAD_DEST] = bad_dest_q;
          close_err_s[ERR_LEN]      = 1'b1;
          close_err_s[ERR_DATA]     = data_err_q;
        end else if (acc_tail_s) begin
          close_s                   = 1'b1;
          close_err_s[ERR_BAD_DEST] = bad_dest_q;
          close_err_s[ERR_LEN]      = (len_q != EXP_LEN);
          close_err_s[ERR_TAIL]     = (flit_src_s != src_q) || (flit_dest_s != dest_q);
          close_err_s[ERR_DATA]     = data_err_q;
        end else begin
          close_s = 1'b0;
        end
      end
      default: begin
        close_s = 1'b0;
      end
    endcase

    // A truncating header closes an errored packet and flags a protocol error: +2.
    err_inc_s = {1'b0, close_s && (close_err_s != {NOC_PKT_ERR_WIDTH{1'b0}})} + {1'b0, proto_s};
    ready_d   = ~(stall_en & (lfsr_s[2:0] == 3'b000));
  end

  // Packet FSM, result registers and counters.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q     <= ST_IDLE;
      src_q       <= {NOC_ID_WIDTH{1'b0}};
      dest_q      <= {NOC_ID_WIDTH{1'b0}};
      len_q       <= 8'd0;
      bad_dest_q  <= 1'b0;
      data_err_q  <= 1'b0;
      ready_q     <= 1'b1;
      pkt_done_q  <= 1'b0;
      pkt_src_q   <= {NOC_ID_WIDTH{1'b0}};
      pkt_len_q   <= 8'd0;
      pkt_err_q   <= {NOC_PKT_ERR_WIDTH{1'b0}};
      proto_err_q <= 1'b0;
      pkt_count_q <= 16'd0;
      err_count_q <= 16'd0;
    end else begin
      ready_q     <= ready_d;
      pkt_done_q  <= close_s;
      proto_err_q <= proto_s;
      err_count_q <= sat_add16(err_count_q, err_inc_s);

      if (close_s) begin
        pkt_src_q <= close_src_s;
        pkt_len_q <= close_len_s;
        pkt_err_q <= close_err_s;
        if (close_err_s == {NOC_PKT_ERR_WIDTH{1'b0}}) begin
          pkt_count_q <= sat_add16(pkt_count_q, 2'd1);
        end else begin
          pkt_count_q <= pkt_count_q;
        end
      end else begin
        pkt_src_q <= pkt_src_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (acc_hdr_s && !receive_is_tail) begin
            src_q      <= flit_src_s;
            dest_q     <= flit_dest_s;
            bad_dest_q <= flit_bad_dest_s;
            len_q      <= 8'd0;
            data_err_q <= 1'b0;
            state_q    <= ST_BODY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BODY: begin
          if (acc_hdr_s) begin
            // New packet opens in the same cycle the old one closes.
            src_q      <= flit_src_s;
            dest_q     <= flit_dest_s;
            bad_dest_q <= flit_bad_dest_s;
            len_q      <= 8'd0;
            data_err_q <= 1'b0;
            state_q    <= ST_BODY;
          end else if (acc_tail_s) begin
            state_q <= ST_IDLE;
          end else if (acc_data_s) begin
            len_q <= len_inc_s;
            if (receive_flit != DATA_PATTERN) begin
              data_err_q <= 1'b1;
            end else begin
              data_err_q <= data_err_q;
            end
          end else begin
            state_q <= ST_BODY;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign receive_ready = ready_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_src_x     = pkt_src_q[NOC_ID_WIDTH-1:NOC_ID_Y_WIDTH];
  assign pkt_src_y     = pkt_src_q[NOC_ID_Y_WIDTH-1:0];
  assign pkt_len       = pkt_len_q;
  assign pkt_err       = pkt_err_q;
  assign proto_err     = proto_err_q;
  assign pkt_count     = pkt_count_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_noc_packet_sink_checker.sv
// -----------------------------------------------------------------------------
// Directed bench for noc_packet_sink_checker (node X=2, Y=3, 11 data flits,
// all-ones data pattern).
// -----------------------------------------------------------------------------
module tb_noc_packet_sink_checker;

  localparam logic [3:0] MY_X = 4'd2;
  localparam logic [3:0] MY_Y = 4'd3;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        valid = 1'b0;
  logic        is_h  = 1'b0;
  logic        is_t  = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] flit  = 32'd0;
  logic        ready;
  logic        done;
  logic [3:0]  src_x;
  logic [3:0]  src_y;
  logic [7:0]  len;
  logic [3:0]  perr;
  logic        proto;
  logic [15:0] pcnt;
  logic [15:0] ecnt;

  int checks = 0;
  int errors = 0;
  int low_cycles = 0;
  int tot_cycles = 0;
  logic measuring = 1'b0;

  noc_packet_sink_checker #(
    .X_ID(MY_X), .Y_ID(MY_Y), .EXP_DATA_LEN(11),
    .DATA_PATTERN(32'hFFFF_FFFF), .LFSR_SEED(8'hA5)
  ) dut (
    .noc_clk(clk), .noc_rst(rst), .receive_valid(valid), .receive_ready(ready),
    .receive_flit(flit), .receive_is_header(is_h), .receive_is_tail(is_t),
    .stall_en(stall), .pkt_done(done), .pkt_src_x(src_x), .pkt_src_y(src_y),
    .pkt_len(len), .pkt_err(perr), .proto_err(proto),
    .pkt_count(pcnt), .err_count(ecnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (measuring) begin
      tot_cycles++;
      if (ready === 1'b0) low_cycles++;
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] sx, input logic [3:0] sy,
                                     input logic [3:0] dx, input logic [3:0] dy);
    return {sx, sy, dx, dy, 16'h0000};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; is_h = 1'b0; is_t = 1'b0; stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one flit, hold it until accepted; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] f, input logic h, input logic t);
    int waits;
    waits = 0;
    valid = 1'b1; flit = f; is_h = h; is_t = t;
    while (ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) begin
      errors++;
      $display("FAIL send_timeout: ready stayed %b, required 1", ready);
    end
    checks++;
    @(negedge clk);
    valid = 1'b0; is_h = 1'b0; is_t = 1'b0;
  endtask

  // Header, n data flits (flit at bad_idx set to 0), tail with same IDs.
  task automatic send_packet(input logic [3:0] sx, input logic [3:0] sy,
                             input logic [3:0] dx, input logic [3:0] dy,
                             input int n, input int bad_idx);
    send(mk(sx, sy, dx, dy), 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      send((i == bad_idx) ? 32'h0000_0000 : 32'hFFFF_FFFF, 1'b0, 1'b0);
    end
    send(mk(sx, sy, dx, dy), 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", done); end
    checks++; if (proto !== 1'b0) begin errors++; $display("FAIL rst_proto: got %b exp 0", proto); end
    checks++; if ({src_x, src_y, len, perr} !== 20'd0) begin errors++; $display("FAIL rst_result: got %h exp 0", {src_x, src_y, len, perr}); end
    checks++; if (pcnt !== 16'd0 || ecnt !== 16'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d exp 0/0", pcnt, ecnt); end
  endtask

  task automatic test_good_packet();
    send_packet(4'd1, 4'd1, MY_X, MY_Y, 11, -1);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL good_done: got %b exp 1", done); end
    checks++; if (len !== 8'd11) begin errors++; $display("FAIL good_len: got %0d exp 11", len); end
    checks++; if (perr !== 4'b0000) begin errors++; $display("FAIL good_err: got %b exp 0000", perr); end
    checks++; if (src_x !== 4'd1 || src_y !== 4'd1) begin errors++; $display("FAIL good_src: got %0d,%0d exp 1,1", src_x, src_y); end
    checks++; if (pcnt !== 16'd1 || ecnt !== 16'd0) begin errors++; $display("FAIL good_counts: got %0d/%0d exp 1/0", pcnt, ecnt); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL good_pulse: got %b exp 0", done); end
    checks++; if (len !== 8'd11) begin errors++; $display("FAIL good_hold: got %0d exp 11", len); end
  endtask

  task automatic test_bad_dest();
    do_reset();
    send_packet(4'd1, 4'd1, 4'd5, MY_Y, 11, -1);
    checks++; if (perr !== 4'b1000) begin errors++; $display("FAIL baddest_err: got %b exp 1000", perr); end
    checks++; if (pcnt !== 16'd0 || ecnt !== 16'd1) begin errors++; $display("FAIL baddest_counts: got %0d/%0d exp 0/1", pcnt, ecnt); end
  endtask

  task automatic test_data_len_err();
    do_reset();
    send_packet(4'd1, 4'd2, MY_X, MY_Y, 10, 4);
    checks++; if (perr !== 4'b0101) begin errors++; $display("FAIL dataerr_err: got %b exp 0101", perr); end
    checks++; if (len !== 8'd10) begin errors++; $display("FAIL dataerr_len: got %0d exp 10", len); end
  endtask

  task automatic test_proto();
    do_reset();
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++; if (proto !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL idle_proto: got %b/%b exp 1/0", proto, done); end
    checks++; if (ecnt !== 16'd1) begin errors++; $display("FAIL idle_proto_cnt: got %0d exp 1", ecnt); end
    send(mk(4'd1, 4'd1, MY_X, MY_Y), 1'b1, 1'b0);
    checks++; if (proto !== 1'b0) begin errors++; $display("FAIL proto_pulse: got %b exp 0", proto); end
    for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(mk(4'd3, 4'd4, MY_X, MY_Y), 1'b1, 1'b0);
    checks++; if (proto !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL midhdr_pulses: got %b/%b exp 1/1", proto, done); end
    checks++; if (len !== 8'd3 || perr !== 4'b0100) begin errors++; $display("FAIL midhdr_result: got len %0d err %b exp 3 0100", len, perr); end
    checks++; if (ecnt !== 16'd3) begin errors++; $display("FAIL midhdr_ecnt: got %0d exp 3", ecnt); end
    for (int i = 0; i < 11; i++) send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(mk(4'd3, 4'd4, MY_X, MY_Y), 1'b0, 1'b1);
    checks++; if (done !== 1'b1 || perr !== 4'b0000) begin errors++; $display("FAIL after_midhdr: got %b/%b exp 1/0000", done, perr); end
    checks++; if (src_x !== 4'd3 || src_y !== 4'd4) begin errors++; $display("FAIL after_midhdr_src: got %0d,%0d exp 3,4", src_x, src_y); end
    checks++; if (pcnt !== 16'd1 || ecnt !== 16'd3) begin errors++; $display("FAIL after_midhdr_counts: got %0d/%0d exp 1/3", pcnt, ecnt); end
  endtask

  task automatic test_single_flit();
    do_reset();
    send(mk(4'd7, 4'd6, MY_X, MY_Y), 1'b1, 1'b1);
    checks++; if (done !== 1'b1 || len !== 8'd0) begin errors++; $display("FAIL single_done: got %b len %0d exp 1 len 0", done, len); end
    checks++; if (perr !== 4'b0100 || src_x !== 4'd7) begin errors++; $display("FAIL single_err: got %b src %0d exp 0100 src 7", perr, src_x); end
    checks++; if (ecnt !== 16'd1) begin errors++; $display("FAIL single_ecnt: got %0d exp 1", ecnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_packet(4'd1, 4'd1, MY_X, MY_Y, 11, -1);
    // Next header goes in on the very next cycle after the tail.
    send(mk(4'd2, 4'd2, MY_X, MY_Y), 1'b1, 1'b0);
    checks++; if (pcnt !== 16'd1 || done !== 1'b0) begin errors++; $display("FAIL b2b_first: got %0d/%b exp 1/0", pcnt, done); end
    for (int i = 0; i < 11; i++) send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(mk(4'd9, 4'd2, MY_X, MY_Y), 1'b0, 1'b1);
    checks++; if (perr !== 4'b0010) begin errors++; $display("FAIL b2b_tail_err: got %b exp 0010", perr); end
    checks++; if (pcnt !== 16'd1 || ecnt !== 16'd1) begin errors++; $display("FAIL b2b_counts: got %0d/%0d exp 1/1", pcnt, ecnt); end
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1;
    measuring = 1'b1;
    for (int p = 0; p < 50; p++) send_packet(4'd1, 4'd0, MY_X, MY_Y, 11, -1);
    measuring = 1'b0;
    stall = 1'b0;
    checks++; if (pcnt !== 16'd50 || ecnt !== 16'd0) begin errors++; $display("FAIL stall_counts: got %0d/%0d exp 50/0", pcnt, ecnt); end
    checks++; if (low_cycles == 0 || low_cycles * 4 > tot_cycles) begin errors++; $display("FAIL stall_ratio: got %0d low of %0d exp about 1/8", low_cycles, tot_cycles); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_packet(4'd1, 4'd1, MY_X, MY_Y, 11, -1);
    send(mk(4'd1, 4'd1, MY_X, MY_Y), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (done !== 1'b0 || proto !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL midrst_ctrl: got %b/%b/%b exp 0/0/1", done, proto, ready); end
    checks++; if ({src_x, src_y, len, perr, pcnt, ecnt} !== 52'd0) begin errors++; $display("FAIL midrst_outs: got %h exp 0", {src_x, src_y, len, perr, pcnt, ecnt}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_nodone: got %b exp 0", done); end
    send_packet(4'd5, 4'd5, MY_X, MY_Y, 11, -1);
    checks++; if (pcnt !== 16'd1 || perr !== 4'b0000 || len !== 8'd11) begin errors++; $display("FAIL midrst_next: got %0d/%b/%0d exp 1/0000/11", pcnt, perr, len); end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_dest();
    test_data_len_err();
    test_proto();
    test_single_flit();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
